// File: rtl/alu_sequencer.sv
// alu_sequencer: control unit for the 8-bit ALU datapath.
// Accepts one operation per req/ready handshake, latches the operand and
// holds the ALU select lines for a settle time. It then writes the ALU result
// into the accumulator and updates the zero flag.
module alu_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] bus_in_i,
  output logic [7:1]       alus_o,
  output logic [WIDTH-1:0] alu_bus_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic [WIDTH-1:0] ac_o,
  output logic             z_o,
  output logic             done_o,
  output logic             err_o
);

  // Counter only needs to hold SETTLE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] alu_bus_q;
  logic [WIDTH-1:0] ac_q;
  logic             z_q;
  logic             done_q;
  logic             err_q;

  // Opcodes 0..8 are defined; 9..15 raise err.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= 4'd8);
  endfunction

  // Select-line pattern for each opcode, bit n of the result drives ALUSn.
  function automatic logic [7:1] decode_alus(input logic [3:0] op);
    logic [7:1] sel;
    case (op)
      4'd0:    sel = 7'b0000011; // ADD
      4'd1:    sel = 7'b0001101; // SUB
      4'd2:    sel = 7'b0001001; // INAC
      4'd3:    sel = 7'b0000000; // CLAC
      4'd4:    sel = 7'b1000000; // AND
      4'd5:    sel = 7'b1010000; // OR
      4'd6:    sel = 7'b1100000; // XOR
      4'd7:    sel = 7'b1110000; // NOT
      4'd8:    sel = 7'b0000010; // LDAC (0 + BUS)
      default: sel = 7'b0000000;
    endcase
    return sel;
  endfunction

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> EXEC/ERR on request, EXEC counts down to WB
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = op_legal(op_i) ? S_EXEC : S_ERR;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state: handshake and select lines
  always_comb begin
    ready_o = 1'b0;
    alus_o  = '0;
    case (state_q)
      S_IDLE:       ready_o = 1'b1;
      S_EXEC, S_WB: alus_o  = decode_alus(op_q);
      default:      alus_o  = '0;
    endcase
  end

  // Datapath registers: operand latch, settle counter, accumulator, flags
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      op_q      <= '0;
      alu_bus_q <= '0;
      ac_q      <= '0;
      z_q       <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            op_q      <= op_i;
            alu_bus_q <= bus_in_i;
            cnt_q     <= CNT_LOAD;
          end
        end
        S_EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WB: begin
          ac_q   <= alu_result_i;
          z_q    <= (alu_result_i == {WIDTH{1'b0}});
          done_q <= 1'b1;
        end
        S_ERR: begin
          err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_bus_o = alu_bus_q;
  assign ac_o      = ac_q;
  assign z_o       = z_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a transaction-level
// reference model. Instance 0 uses SETTLE_CYCLES=1 and instance 1 uses
// SETTLE_CYCLES=3. A stand-in ALU turns the select lines into a result.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n   [2];
  logic       req     [2];
  logic [3:0] op      [2];
  logic [7:0] bus_in  [2];
  logic       ready   [2];
  logic [7:1] alus    [2];
  logic [7:0] alu_bus [2];
  logic [7:0] alu_res [2];
  logic [7:0] ac      [2];
  logic       z       [2];
  logic       done    [2];
  logic       err     [2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .req_i(req[0]), .ready_o(ready[0]),
    .op_i(op[0]), .bus_in_i(bus_in[0]), .alus_o(alus[0]), .alu_bus_o(alu_bus[0]),
    .alu_result_i(alu_res[0]), .ac_o(ac[0]), .z_o(z[0]), .done_o(done[0]), .err_o(err[0])
  );

  alu_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .req_i(req[1]), .ready_o(ready[1]),
    .op_i(op[1]), .bus_in_i(bus_in[1]), .alus_o(alus[1]), .alu_bus_o(alu_bus[1]),
    .alu_result_i(alu_res[1]), .ac_o(ac[1]), .z_o(z[1]), .done_o(done[1]), .err_o(err[1])
  );

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Stand-in for the ALU: result from the select-line pattern, AC and BUS.
  function automatic logic [7:0] alu_stub(input logic [7:1] sel, input logic [7:0] a,
                                          input logic [7:0] b);
    case (sel)
      7'b0000011: return a + b;
      7'b0001101: return a - b;
      7'b0001001: return a + 8'd1;
      7'b1000000: return a & b;
      7'b1010000: return a | b;
      7'b1100000: return a ^ b;
      7'b1110000: return ~a;
      7'b0000010: return b;
      default:    return 8'h00;
    endcase
  endfunction

  assign alu_res[0] = alu_stub(alus[0], ac[0], alu_bus[0]);
  assign alu_res[1] = alu_stub(alus[1], ac[1], alu_bus[1]);

  // Reference model: opcode semantics as plain arithmetic.
  function automatic logic [7:0] op_result(input logic [3:0] o, input logic [7:0] a,
                                           input logic [7:0] b);
    case (o)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a + 8'd1;
      4'd3:    return 8'h00;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~a;
      4'd8:    return b;
      default: return a;
    endcase
  endfunction

  function automatic logic [7:1] op_sel(input logic [3:0] o);
    case (o)
      4'd0:    return 7'b0000011;
      4'd1:    return 7'b0001101;
      4'd2:    return 7'b0001001;
      4'd4:    return 7'b1000000;
      4'd5:    return 7'b1010000;
      4'd6:    return 7'b1100000;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b0000010;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Model state, one set per instance. A pending transaction completes at
  // edge m_end: accept edge + settle + 1 for legal ops, + 1 for illegal ops.
  int         cyc = 0;
  logic [7:0] m_ac   [2];
  logic [7:0] m_bus  [2];
  logic       m_z    [2];
  bit         m_pend [2];
  bit         m_legal[2];
  logic [3:0] m_op   [2];
  logic [7:0] m_res  [2];
  int         m_end  [2];
  bit         m_done [2];
  bit         m_err  [2];
  int         dut_done_cnt [2];
  int         exp_done_cnt [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ac[k] = 8'h00; m_bus[k] = 8'h00; m_z[k] = 1'b0; m_pend[k] = 1'b0;
      m_legal[k] = 1'b0; m_op[k] = 4'h0; m_res[k] = 8'h00; m_end[k] = 0;
      m_done[k] = 1'b0; m_err[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        m_done[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (!rst_n[k]) begin
          m_ac[k] = 8'h00; m_z[k] = 1'b0; m_bus[k] = 8'h00; m_pend[k] = 1'b0;
        end else if (m_pend[k]) begin
          if (cyc == m_end[k]) begin
            m_pend[k] = 1'b0;
            if (m_legal[k]) begin
              m_ac[k]   = m_res[k];
              m_z[k]    = (m_res[k] == 8'h00);
              m_done[k] = 1'b1;
            end else begin
              m_err[k] = 1'b1;
            end
          end
        end else if (req[k]) begin
          m_pend[k]  = 1'b1;
          m_op[k]    = op[k];
          m_bus[k]   = bus_in[k];
          m_legal[k] = (op[k] <= 4'd8);
          m_res[k]   = op_result(op[k], m_ac[k], bus_in[k]);
          m_end[k]   = cyc + (m_legal[k] ? settle_of(k) + 1 : 1);
        end
      end
    end
  end

  // Compare every DUT output against the model, half a cycle after each edge.
  initial begin
    dut_done_cnt[0] = 0;
    dut_done_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int k = 0; k < 2; k++) begin
          chk("m_ready",   k, 32'(ready[k]),   32'(!m_pend[k]));
          chk("m_alus",    k, 32'(alus[k]),
              32'((m_pend[k] && m_legal[k]) ? op_sel(m_op[k]) : 7'b0000000));
          chk("m_ac",      k, 32'(ac[k]),      32'(m_ac[k]));
          chk("m_z",       k, 32'(z[k]),       32'(m_z[k]));
          chk("m_done",    k, 32'(done[k]),    32'(m_done[k]));
          chk("m_err",     k, 32'(err[k]),     32'(m_err[k]));
          chk("m_alu_bus", k, 32'(alu_bus[k]), 32'(m_bus[k]));
          if (done[k] === 1'b1) dut_done_cnt[k]++;
        end
      end
    end
  end

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (ready[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ready[k] !== 1'b1) chk("ready_timeout", k, 32'(ready[k]), 32'(1));
  endtask

  // One legal operation; hand-computed result, select lines and latency.
  // With hold set, req stays high (with garbage op/bus) until the done cycle.
  task automatic do_op(input int k, input logic [3:0] o, input logic [7:0] b,
                       input logic [7:0] exp_ac, input logic exp_z,
                       input logic [7:1] exp_sel, input bit hold);
    int n;
    wait_ready(k);
    req[k] = 1'b1; op[k] = o; bus_in[k] = b;
    @(negedge clk);
    n = 1;
    chk("exec_alus", k, 32'(alus[k]), 32'(exp_sel));
    if (hold) begin
      op[k] = 4'hC; bus_in[k] = 8'h11;
    end else begin
      req[k] = 1'b0;
    end
    while (done[k] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    req[k] = 1'b0;
    exp_done_cnt[k]++;
    chk("latency", k, 32'(n), 32'(settle_of(k) + 2));
    chk("ac", k, 32'(ac[k]), 32'(exp_ac));
    chk("z", k, 32'(z[k]), 32'(exp_z));
    $display("op dut%0d op=%0h bus=%02h ac=%02h z=%0b edges=%0d", k, o, b, ac[k], z[k], n);
  endtask

  // Illegal opcode: err pulses on the second edge, ac/z untouched.
  task automatic do_illegal(input int k, input logic [3:0] o, input logic [7:0] b,
                            input logic [7:0] exp_ac, input logic exp_z);
    wait_ready(k);
    req[k] = 1'b1; op[k] = o; bus_in[k] = b;
    @(negedge clk);
    req[k] = 1'b0;
    chk("ill_err0",  k, 32'(err[k]),   32'(0));
    chk("ill_ready", k, 32'(ready[k]), 32'(0));
    chk("ill_alus",  k, 32'(alus[k]),  32'(0));
    @(negedge clk);
    chk("ill_err1",  k, 32'(err[k]),   32'(1));
    chk("ill_rdy1",  k, 32'(ready[k]), 32'(1));
    chk("ill_done",  k, 32'(done[k]),  32'(0));
    chk("ill_ac",    k, 32'(ac[k]),    32'(exp_ac));
    chk("ill_z",     k, 32'(z[k]),     32'(exp_z));
    $display("illegal dut%0d op=%0h err=%0b ac=%02h z=%0b", k, o, err[k], ac[k], z[k]);
  endtask

  initial begin
    int snap;
    exp_done_cnt[0] = 0;
    exp_done_cnt[1] = 0;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; op[k] = 4'h0; bus_in[k] = 8'h00;
    end
    // Reset held for two edges on both instances
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ac",    k, 32'(ac[k]),    32'(8'h00));
      chk("rst_z",     k, 32'(z[k]),     32'(0));
      chk("rst_ready", k, 32'(ready[k]), 32'(1));
      chk("rst_done",  k, 32'(done[k]),  32'(0));
      chk("rst_err",   k, 32'(err[k]),   32'(0));
      chk("rst_alus",  k, 32'(alus[k]),  32'(0));
      $display("reset dut%0d ac=%02h z=%0b ready=%0b", k, ac[k], z[k], ready[k]);
      rst_n[k] = 1'b1;
    end

    // Instance 0 (settle 1): back-to-back directed sequence
    do_op(0, 4'd8, 8'h5A, 8'h5A, 1'b0, 7'b0000010, 1'b0); // LDAC
    do_op(0, 4'd0, 8'h26, 8'h80, 1'b0, 7'b0000011, 1'b0); // ADD
    do_op(0, 4'd1, 8'h80, 8'h00, 1'b1, 7'b0001101, 1'b0); // SUB
    do_op(0, 4'd8, 8'hFF, 8'hFF, 1'b0, 7'b0000010, 1'b0); // LDAC
    do_op(0, 4'd2, 8'h00, 8'h00, 1'b1, 7'b0001001, 1'b0); // INAC wraps
    do_op(0, 4'd8, 8'hF0, 8'hF0, 1'b0, 7'b0000010, 1'b0); // LDAC
    do_op(0, 4'd6, 8'hFF, 8'h0F, 1'b0, 7'b1100000, 1'b0); // XOR
    do_op(0, 4'd7, 8'hAA, 8'hF0, 1'b0, 7'b1110000, 1'b0); // NOT
    do_op(0, 4'd4, 8'h3C, 8'h30, 1'b0, 7'b1000000, 1'b0); // AND
    do_op(0, 4'd5, 8'h0F, 8'h3F, 1'b0, 7'b1010000, 1'b0); // OR
    do_op(0, 4'd3, 8'h55, 8'h00, 1'b1, 7'b0000000, 1'b0); // CLAC
    do_op(0, 4'd8, 8'h7E, 8'h7E, 1'b0, 7'b0000010, 1'b0); // LDAC
    do_illegal(0, 4'hC, 8'h99, 8'h7E, 1'b0);
    do_illegal(0, 4'h9, 8'h01, 8'h7E, 1'b0);
    do_illegal(0, 4'hF, 8'h02, 8'h7E, 1'b0);
    do_op(0, 4'd0, 8'h01, 8'h7F, 1'b0, 7'b0000011, 1'b1); // ADD, req held
    do_op(0, 4'd1, 8'h7F, 8'h00, 1'b1, 7'b0001101, 1'b0); // SUB to zero

    // Instance 1 (settle 3): latency, then reset mid-EXEC
    do_op(1, 4'd8, 8'h44, 8'h44, 1'b0, 7'b0000010, 1'b0); // LDAC
    do_op(1, 4'd0, 8'h10, 8'h54, 1'b0, 7'b0000011, 1'b0); // ADD
    wait_ready(1);
    req[1] = 1'b1; op[1] = 4'd0; bus_in[1] = 8'h01;
    @(negedge clk);          // first EXEC cycle
    req[1] = 1'b0;
    @(negedge clk);          // second EXEC cycle
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    chk("abort_ac",    1, 32'(ac[1]),    32'(8'h00));
    chk("abort_ready", 1, 32'(ready[1]), 32'(1));
    chk("abort_alus",  1, 32'(alus[1]),  32'(0));
    snap = dut_done_cnt[1];
    repeat (8) @(negedge clk);
    chk("abort_nodone", 1, 32'(dut_done_cnt[1]), 32'(snap));
    $display("abort dut1 ac=%02h ready=%0b dones=%0d", ac[1], ready[1], dut_done_cnt[1]);

    chk("done_count", 0, 32'(dut_done_cnt[0]), 32'(exp_done_cnt[0]));
    chk("done_count", 1, 32'(dut_done_cnt[1]), 32'(exp_done_cnt[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
